// File: rtl/ooo_types.sv
// Shared out-of-order core types: ROB tag width and completion record layout.
package ooo_types;

  localparam int unsigned ROB_BITS  = 6;
  localparam int unsigned N_CPL_REQ = 3;

  typedef struct packed {
    logic [ROB_BITS-1:0] tag;
    logic                branch_taken;
    logic [31:0]         branch_target;
  } cpl_req_t;

endpackage

// File: rtl/cpl_fifo.sv
// Small circular FIFO of completion records with synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module cpl_fifo
  import ooo_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     push,
  input  cpl_req_t push_data,
  input  logic     pop,
  output cpl_req_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  cpl_req_t      r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == (PW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_push = push & (~full | pop);
  assign w_do_pop  = pop & ~empty;

  // Pointer and occupancy state; flush empties the FIFO in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Record storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rob_cpl_arbiter.sv
// Round-robin arbiter feeding the ROB's single completion port from N_REQ
// per-unit FIFOs. Optional macro ROB_CPL_ARB_BYPASS_EN lets a lone request
// skip its FIFO when all FIFOs are empty (1-edge latency).
module rob_cpl_arbiter
  import ooo_types::*;
#(
  parameter int unsigned N_REQ      = N_CPL_REQ,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ROB_BITS-1:0] req_tag,
  input  logic [N_REQ-1:0]          req_branch_taken,
  input  logic [N_REQ*32-1:0]       req_branch_target,
  output logic                      complete_en,
  output logic [ROB_BITS-1:0]       complete_tag,
  output logic                      branch_taken,
  output logic [31:0]               branch_target,
  output logic                      busy
);

  localparam int unsigned RRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  cpl_req_t         w_req  [N_REQ];
  cpl_req_t         w_head [N_REQ];
  logic [N_REQ-1:0] w_full;
  logic [N_REQ-1:0] w_empty;
  logic [N_REQ-1:0] w_push;
  logic [N_REQ-1:0] w_pop;

  logic [RRW-1:0]   r_rr_ptr;
  logic [RRW-1:0]   w_rr_d;
  logic             r_en;
  logic             w_en_d;
  cpl_req_t         r_out;
  cpl_req_t         w_out_d;

  logic             w_found;
  logic [RRW-1:0]   w_win;
  logic [RRW:0]     w_cand;
  logic             w_bypass;
  logic [RRW-1:0]   w_byp_idx;

  assign req_ready = ~w_full;
  // Flushed or bypassed records never enter a FIFO.
  assign w_push    = req_valid & req_ready & ~{N_REQ{flush}} & ~{N_REQ{w_bypass}};

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign w_req[gi] = cpl_req_t'{
      tag:           req_tag[gi*ROB_BITS +: ROB_BITS],
      branch_taken:  req_branch_taken[gi],
      branch_target: req_branch_target[gi*32 +: 32]
    };
    assign w_pop[gi] = w_found & (w_win == RRW'(gi)) & ~flush;

    cpl_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (w_push[gi]),
      .push_data (w_req[gi]),
      .pop       (w_pop[gi]),
      .head      (w_head[gi]),
      .full      (w_full[gi]),
      .empty     (w_empty[gi])
    );
  end

  // Round-robin pick: first non-empty FIFO at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (RRW+1)'(k);
      if (w_cand >= (RRW+1)'(N_REQ)) w_cand = w_cand - (RRW+1)'(N_REQ);
      if (!w_found && !w_empty[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand[RRW-1:0];
      end
    end
  end

  // Bypass qualification: idle FIFOs, a single valid unit, no flush.
  always_comb begin
    w_bypass  = 1'b0;
    w_byp_idx = '0;
`ifdef ROB_CPL_ARB_BYPASS_EN
    w_bypass = (&w_empty) & $onehot(req_valid) & ~flush;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) w_byp_idx = RRW'(i);
    end
`endif
  end

  // Next output record, pulse and round-robin pointer.
  always_comb begin
    w_rr_d  = r_rr_ptr;
    w_en_d  = 1'b0;
    w_out_d = r_out;
    if (flush) begin
      w_en_d = 1'b0;
    end else if (w_bypass) begin
      w_en_d  = 1'b1;
      w_out_d = w_req[w_byp_idx];
      w_rr_d  = (w_byp_idx == RRW'(N_REQ - 1)) ? '0 : w_byp_idx + RRW'(1);
    end else if (w_found) begin
      w_en_d  = 1'b1;
      w_out_d = w_head[w_win];
      w_rr_d  = (w_win == RRW'(N_REQ - 1)) ? '0 : w_win + RRW'(1);
    end
  end

  // Registered completion port and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_en     <= 1'b0;
      r_out    <= '0;
    end else begin
      r_rr_ptr <= w_rr_d;
      r_en     <= w_en_d;
      r_out    <= w_out_d;
    end
  end

  assign complete_en   = r_en;
  assign complete_tag  = r_out.tag;
  assign branch_taken  = r_out.branch_taken;
  assign branch_target = r_out.branch_target;
  assign busy          = ~(&w_empty) | r_en;

endmodule

// File: tb/tb_rob_cpl_arbiter.sv
// Self-checking bench for rob_cpl_arbiter: directed scenarios followed by
// random traffic, compared each cycle against a queue-based reference model.
module tb_rob_cpl_arbiter;
  import ooo_types::*;

  localparam int unsigned N  = 3;
  localparam int unsigned FD = 2;
  localparam int unsigned RB = ROB_BITS;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*RB-1:0] req_tag;
  logic [N-1:0]    req_branch_taken;
  logic [N*32-1:0] req_branch_target;
  logic            complete_en;
  logic [RB-1:0]   complete_tag;
  logic            branch_taken;
  logic [31:0]     branch_target;
  logic            busy;

  rob_cpl_arbiter #(
    .N_REQ      (N),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_tag           (req_tag),
    .req_branch_taken  (req_branch_taken),
    .req_branch_target (req_branch_target),
    .complete_en       (complete_en),
    .complete_tag      (complete_tag),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RB-1:0] tag;
    logic          tk;
    logic [31:0]   tgt;
  } rec_t;

  // Reference model: one queue per unit, a rotating priority index, output copy.
  rec_t          mq[N][$];
  int            m_rr;
  logic          m_en;
  logic [RB-1:0] m_tag;
  logic          m_tk;
  logic [31:0]   m_tgt;
  logic [N-1:0]  m_acc;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [RB-1:0] t, input logic k,
                         input logic [31:0] g);
    req_valid[i]                = v;
    req_tag[i*RB +: RB]         = t;
    req_branch_taken[i]         = k;
    req_branch_target[i*32 +: 32] = g;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr  = 0;
    m_en  = 1'b0;
    m_tag = '0;
    m_tk  = 1'b0;
    m_tgt = '0;
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    int   tot;
    int   win;
    int   bidx;
    bit   byp;
    rec_t r;
    tot = 0;
    for (int i = 0; i < N; i++) begin
      m_acc[i] = req_valid[i] && (mq[i].size() < FD);
      tot += mq[i].size();
    end
    if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_en = 1'b0;
      return;
    end
    byp  = 1'b0;
    bidx = 0;
`ifdef ROB_CPL_ARB_BYPASS_EN
    if (tot == 0 && $countones(req_valid) == 1) begin
      byp = 1'b1;
      for (int i = 0; i < N; i++) if (req_valid[i]) bidx = i;
    end
`endif
    if (byp) begin
      m_en  = 1'b1;
      m_tag = req_tag[bidx*RB +: RB];
      m_tk  = req_branch_taken[bidx];
      m_tgt = req_branch_target[bidx*32 +: 32];
      m_rr  = (bidx + 1) % N;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && mq[(m_rr + k) % N].size() > 0) win = (m_rr + k) % N;
      end
      if (win >= 0) begin
        r     = mq[win].pop_front();
        m_en  = 1'b1;
        m_tag = r.tag;
        m_tk  = r.tk;
        m_tgt = r.tgt;
        m_rr  = (win + 1) % N;
      end else begin
        m_en = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_acc[i] && !(byp && i == bidx)) begin
        r.tag = req_tag[i*RB +: RB];
        r.tk  = req_branch_taken[i];
        r.tgt = req_branch_target[i*32 +: 32];
        mq[i].push_back(r);
      end
    end
  endtask

  // One clock: check ready now, step the model, check registered outputs after the edge.
  task automatic step();
    int tot;
    for (int i = 0; i < N; i++) chk($sformatf("req_ready[%0d]", i), 64'(req_ready[i]),
                                     64'(mq[i].size() < FD));
    model_edge();
    @(posedge clk);
    #1;
    tot = 0;
    for (int i = 0; i < N; i++) tot += mq[i].size();
    chk("complete_en", 64'(complete_en), 64'(m_en));
    chk("complete_tag", 64'(complete_tag), 64'(m_tag));
    chk("branch_taken", 64'(branch_taken), 64'(m_tk));
    chk("branch_target", 64'(branch_target), 64'(m_tgt));
    chk("busy", 64'(busy), 64'(m_en || tot > 0));
  endtask

  logic [RB-1:0] pend_tag [N];
  logic          pend_tk  [N];
  logic [31:0]   pend_tgt [N];
  logic          pend     [N];

  initial begin
    int            bru_sent;
    int            seen;
    logic [RB-1:0] cap_tag;
    logic          cap_tk;
    logic [31:0]   cap_tgt;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_branch_taken  = '0;
    req_branch_target = '0;
    model_reset();

    // Reset values.
    #12;
    chk("rst_complete_en", 64'(complete_en), 64'(0));
    chk("rst_complete_tag", 64'(complete_tag), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(3'b111));
    rst_n = 1'b1;

    // Single requester: ALU tags 3, 4, 5 on consecutive edges.
    for (int t = 3; t <= 5; t++) begin
      set_req(0, 1'b1, RB'(t), 1'b0, 32'(t * 4));
      step();
    end
    clear_reqs();
    repeat (4) step();

    // Fairness: two records per unit pushed together.
    set_req(0, 1'b1, RB'(1), 1'b0, 32'h100);
    set_req(1, 1'b1, RB'(7), 1'b1, 32'h200);
    set_req(2, 1'b1, RB'(10), 1'b0, 32'h300);
    step();
    set_req(0, 1'b1, RB'(2), 1'b0, 32'h104);
    set_req(1, 1'b1, RB'(8), 1'b0, 32'h204);
    set_req(2, 1'b1, RB'(11), 1'b1, 32'h304);
    step();
    clear_reqs();
    repeat (8) step();

    // Backpressure: BRU holds three records against ALU/LSU traffic.
    bru_sent = 0;
    for (int c = 0; c < 16 && bru_sent < 3; c++) begin
      set_req(0, 1'b1, RB'(20 + c), 1'b0, $urandom);
      set_req(2, 1'b1, RB'(40 + c), 1'b0, $urandom);
      set_req(1, 1'b1, RB'(30 + bru_sent), 1'b1, 32'h1000 + 32'(bru_sent));
      step();
      if (m_acc[1]) bru_sent++;
    end
    chk("bru_all_accepted", 64'(bru_sent), 64'(3));
    clear_reqs();
    repeat (10) step();

    // Branch data through BRU.
    set_req(1, 1'b1, RB'(6), 1'b1, 32'h0000_0400);
    step();
    clear_reqs();
    seen    = 0;
    cap_tag = '0;
    cap_tk  = 1'b0;
    cap_tgt = '0;
    if (complete_en) begin
      seen = 1; cap_tag = complete_tag; cap_tk = branch_taken; cap_tgt = branch_target;
    end
    for (int c = 0; c < 4 && seen == 0; c++) begin
      step();
      if (complete_en) begin
        seen = 1; cap_tag = complete_tag; cap_tk = branch_taken; cap_tgt = branch_target;
      end
    end
    chk("branch_seen", 64'(seen), 64'(1));
    chk("branch_tag", 64'(cap_tag), 64'(6));
    chk("branch_taken_val", 64'(cap_tk), 64'(1));
    chk("branch_target_val", 64'(cap_tgt), 64'h400);
    repeat (3) step();

    // Flush with four records buffered and a new LSU request (tag 9).
    set_req(0, 1'b1, RB'(12), 1'b0, 32'h10);
    set_req(1, 1'b1, RB'(13), 1'b0, 32'h14);
    set_req(2, 1'b1, RB'(14), 1'b0, 32'h18);
    step();
    set_req(2, 1'b0, '0, 1'b0, '0);
    set_req(0, 1'b1, RB'(15), 1'b0, 32'h1c);
    set_req(1, 1'b1, RB'(16), 1'b0, 32'h20);
    step();
    clear_reqs();
    set_req(2, 1'b1, RB'(9), 1'b0, 32'h24);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_reqs();
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_ready", 64'(req_ready), 64'(3'b111));
    for (int c = 0; c < 4; c++) begin
      step();
      chk("flush_no_tag9", 64'(complete_en && complete_tag == RB'(9)), 64'(0));
    end

    // Asynchronous reset mid-stream with records buffered.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, RB'(50 + i), 1'b1, 32'hdead_0000 + 32'(i));
    step();
    step();
    clear_reqs();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_complete_en", 64'(complete_en), 64'(0));
    chk("mid_rst_complete_tag", 64'(complete_tag), 64'(0));
    chk("mid_rst_branch_taken", 64'(branch_taken), 64'(0));
    chk("mid_rst_branch_target", 64'(branch_target), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_req_ready", 64'(req_ready), 64'(3'b111));
    #2;
    rst_n = 1'b1;
    repeat (3) step();

    // Random traffic: units hold valid until accepted; occasional flushes.
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 55) begin
          pend[i]     = 1'b1;
          pend_tag[i] = RB'($urandom);
          pend_tk[i]  = 1'($urandom);
          pend_tgt[i] = $urandom;
        end
        set_req(i, pend[i], pend_tag[i], pend_tk[i], pend_tgt[i]);
      end
      flush = ($urandom_range(0, 29) == 0);
      step();
      for (int i = 0; i < N; i++) if (m_acc[i]) pend[i] = 1'b0;
    end
    flush = 1'b0;
    clear_reqs();
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
